clk_divider: RTL and testbench
==============================

# clk_divider

Programmable integer clock divider: takes one source clock and produces `o_clk` at `i_clk / N`, where N comes from an 8-bit divisor word. A new divisor is committed through a toggle handshake and applied only on an output-period boundary, so `o_clk` never glitches or produces runt pulses. Sits at clock-generation level, feeding downstream logic that needs a slower, run-time-selectable clock.

## Interface
- No parameters; divisor width is fixed at 8 bits (`DIV_W = 8`, package constant).
- `i_clk`  in  1  source clock; all state on this clock, with a falling-edge stage for odd-divisor duty correction and bypass gating.
- `i_rstn`  in  1  asynchronous, active-high reset (name kept for codebase compatibility; polarity is high-active).
- `i_div`  in  8  requested divisor N; must be stable whenever `i_div_tog` changes and for 3 `i_clk` cycles afterwards.
- `i_div_tog`  in  1  toggle request; every level change (0→1 or 1→0) requests loading `i_div`. May be asynchronous to `i_clk`.
- `o_clk`  out  1  divided clock.

## Operation
- Divisor meaning: N=0 or N=1 → bypass (`o_clk` follows `i_clk`); N≥2 → divide by N.
- Request path: `i_div_tog` passes through a 2-flop synchronizer, then an edge detector (XOR with the previous synchronized value). On a detected edge, capture `i_div` into `pend_div` and set `pend_vld`.
- Active divisor `act_div` changes only at a period boundary, i.e. the cycle where counter `cnt` wraps N-1→0 while in divide mode, or on any falling edge while in bypass. On that boundary: `act_div <= pend_div`, clear `pend_vld`, `cnt <= 0`.
- Divide mode: `cnt` counts 0..N-1 on rising `i_clk`.
  - Even N: registered `p` is high while `cnt < N/2`; `o_clk = p`. Duty is 50%.
  - Odd N: `p` is high while `cnt < (N-1)/2`. `n` is `p` re-registered on falling `i_clk`. `o_clk = p | n`, giving a high time of N/2 source periods (50%).
- Bypass: enable flop `byp` updates on falling `i_clk`; `o_clk = (byp & i_clk) | divided_out`.
  - Enter bypass only when the divided output is low.
  - When leaving bypass, clear `byp` on a falling edge. The counter then starts at `cnt = 0` on the next rising edge.
- A second toggle that arrives before commit overwrites `pend_div`; the last value wins.
- Reset, any time: `o_clk = 0`, `cnt = 0`, `p = n = 0`, `act_div = 0`, `pend_vld = 0`, synchronizer flops = 0, `byp = 0`. After reset is released, `byp` sets on the first falling edge (`act_div = 0` means bypass).
- Width rule: `cnt` is 8 bits and is compared against `act_div - 1` (unsigned). N=255 is legal.

## Timing
- Toggle to capture: 3 rising `i_clk` edges (2 for synchronization, 1 for edge detection and capture).
- Capture to commit: up to N source cycles (the remainder of the current output period), or ≤1 cycle in bypass.
- In divide mode, the first rising edge of `o_clk` after a commit is aligned with the rising `i_clk` edge where `cnt = 0`, plus flop clk-to-q.
- `o_clk` rises only from a flop or gated-clock path. No combinational glitch is permitted at any transition: mode switch, divisor change, or reset release.
- Output period equals exactly N source periods from the first full period after commit.

## Structure
- Package `clk_div_pkg`: `DIV_W = 8`; typedef `div_t = logic [DIV_W-1:0]`; localparams `BYPASS_MAX = 1`, `SYNC_STAGES = 2`.
- One natural sub-module: `tog_sync`. It contains the 2-flop synchronizer and edge detector, and outputs a one-cycle `req` pulse.
- The top level holds the pending/active registers, counter, p/n duty flops and bypass gating.

## Test plan
- Reset with `i_div = 0`, `i_rstn = 1` for 100 ns, then release → `o_clk = 0` during reset, then follows `i_clk` (bypass).
- Toggle with `i_div = 4` → within 3 cycles plus the boundary, `o_clk` period = 4×`i_clk` period, high 2 cycles and low 2 cycles.
- Toggle with `i_div = 5` → period = 5 source periods, high time 2.5 source periods, no glitch at the switch.
- Switch 4→1 and then 1→6 mid-period → no pulse shorter than the shorter of the old and new half-periods; bypass then a ÷6 output.
- Two toggles 1 cycle apart with values 3 then 7 → only ÷7 is applied.
- Assert reset mid-period at N=9 → `o_clk` goes low immediately; after release, bypass until a new toggle arrives.
- Random N in 0..15, toggled every 2210 ns for 100 iterations → the checker confirms the period and duty for every N and no runt pulses.

Source files
------------

// File: rtl/clk_divider_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants, types and small helpers for the programmable clock
// divider.
//   DIV_W       : divisor word width
//   div_t       : divisor word type
//   BYPASS_MAX  : largest divisor value that selects bypass (o_clk = i_clk)
//   SYNC_STAGES : flop count of the toggle-request synchronizer
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package clk_div_pkg;

  localparam int DIV_W = 8;

  typedef logic [DIV_W-1:0] div_t;

  localparam div_t BYPASS_MAX  = 8'd1;
  localparam int   SYNC_STAGES = 2;

  // Divisors 0 and 1 both mean "pass the source clock straight through".
  function automatic logic is_bypass(input div_t d);
    return (d <= BYPASS_MAX);
  endfunction

  // Number of rising-edge cycles the registered phase p stays high.
  // Even N gives N/2 and odd N gives (N-1)/2; both are N >> 1.
  function automatic div_t high_count(input div_t d);
    return {1'b0, d[DIV_W-1:1]};
  endfunction

endpackage

// File: rtl/clk_divider_tog_sync.sv
// -----------------------------------------------------------------------------
// tog_sync
// Brings the (possibly asynchronous) divisor toggle into the source clock
// domain and turns every level change into a one-cycle request pulse.
//   clk_i : source clock
//   rst_i : asynchronous active-high reset
//   tog_i : toggle request, any level change is a request
//   req_o : one-cycle pulse, high in the cycle after the synchronized toggle
//           changes level
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tog_sync
  import clk_div_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic tog_i,
  output logic req_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain plus the previous synchronized value for edge detect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Both inputs come straight from flops, so the pulse is clean.
  assign req_o = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/clk_divider.sv
// -----------------------------------------------------------------------------
// clk_divider
// Programmable integer clock divider. o_clk runs at i_clk / N where N is the
// committed divisor; N = 0 or 1 passes i_clk through. A new divisor is
// requested by toggling i_div_tog and takes effect only on an output-period
// boundary, so o_clk never produces a runt pulse.
//   i_clk     : source clock (rising edge for the counter, falling edge for
//               odd-duty correction and bypass gating)
//   i_rstn    : asynchronous reset, ACTIVE HIGH despite the name
//   i_div     : requested divisor, stable around each toggle
//   i_div_tog : toggle request, may be asynchronous to i_clk
//   o_clk     : divided clock
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module clk_divider
  import clk_div_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_div_tog,
  output logic             o_clk
);

  // Request path
  logic req_s;

  // Rising-edge state
  div_t pend_div_q, pend_div_d;
  logic pend_vld_q, pend_vld_d;
  div_t act_div_q,  act_div_d;
  div_t cnt_q,      cnt_d;
  logic run_q,      run_d;   // divide counter has started its first period
  logic p_q,        p_d;

  // Falling-edge state
  logic n_q, n_d;
  logic byp_q, byp_d;

  // Combinational helpers
  logic wrap_s;
  logic commit_s;
  div_t cnt_inc_s;

  tog_sync u_tog_sync (
    .clk_i (i_clk),
    .rst_i (i_rstn),
    .tog_i (i_div_tog),
    .req_o (req_s)
  );

  assign wrap_s    = (cnt_q == (act_div_q - 8'd1));
  assign cnt_inc_s = cnt_q + 8'd1;

  // Next-state logic for counter, duty phase, commit and pending divisor.
  always_comb begin
    cnt_d      = cnt_q;
    run_d      = run_q;
    p_d        = p_q;
    act_div_d  = act_div_q;
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;
    commit_s   = 1'b0;

    if (is_bypass(act_div_q)) begin
      // Bypass: every cycle is a boundary, so a pending divisor commits now.
      commit_s = pend_vld_q;
      cnt_d    = 8'd0;
      run_d    = 1'b0;
      p_d      = 1'b0;
    end else if (byp_q) begin
      // Leaving bypass: hold the divider idle until the gate closes on the
      // next falling edge.
      cnt_d = 8'd0;
      run_d = 1'b0;
      p_d   = 1'b0;
    end else if (!run_q) begin
      // First divided period starts here with cnt = 0 and p high.
      cnt_d = 8'd0;
      run_d = 1'b1;
      p_d   = 1'b1;
    end else if (wrap_s) begin
      // Period boundary: p and n are both low here, safe to change divisor.
      commit_s = pend_vld_q;
      cnt_d    = 8'd0;
      if (commit_s) begin
        act_div_d = pend_div_q;
      end else begin
        act_div_d = act_div_q;
      end
      run_d = !is_bypass(act_div_d);
      p_d   = !is_bypass(act_div_d);
    end else begin
      cnt_d = cnt_inc_s;
      p_d   = (cnt_inc_s < high_count(act_div_q));
    end

    if (commit_s) begin
      act_div_d = pend_div_q;
    end else begin
      act_div_d = act_div_d;
    end

    // A request landing on a commit cycle stays pending for the next boundary.
    if (req_s) begin
      pend_div_d = i_div;
      pend_vld_d = 1'b1;
    end else if (commit_s) begin
      pend_vld_d = 1'b0;
    end else begin
      pend_vld_d = pend_vld_q;
    end
  end

  // Rising-edge registers.
  always_ff @(posedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      pend_div_q <= 8'd0;
      pend_vld_q <= 1'b0;
      act_div_q  <= 8'd0;
      cnt_q      <= 8'd0;
      run_q      <= 1'b0;
      p_q        <= 1'b0;
    end else begin
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      act_div_q  <= act_div_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      p_q        <= p_d;
    end
  end

  // Falling-edge next state: odd-duty half-cycle stretch and bypass gate.
  always_comb begin
    // n only stretches the high phase for odd divisors.
    n_d = p_q & act_div_q[0];
    if (is_bypass(act_div_q)) begin
      // Open the gate only while the divided output is low.
      byp_d = byp_q | (~p_q & ~n_q);
    end else begin
      byp_d = 1'b0;
    end
  end

  // Falling-edge registers; byp changes while i_clk is low, so the gate
  // output cannot glitch.
  always_ff @(negedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      n_q   <= 1'b0;
      byp_q <= 1'b0;
    end else begin
      n_q   <= n_d;
      byp_q <= byp_d;
    end
  end

  assign o_clk = (byp_q & i_clk) | p_q | n_q;

endmodule

// File: tb/tb_clk_divider.sv
`timescale 1ns/1ps
module tb_clk_divider;

  logic       i_clk = 1'b0;
  logic       i_rstn;
  logic [7:0] i_div;
  logic       i_div_tog;
  logic       o_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Output run monitor (units: half source periods)
  bit   mon_started = 1'b0;
  bit   partial     = 1'b1;
  bit   runt_en     = 1'b0;
  logic cur_lvl     = 1'b0;
  int   cur_len     = 0;
  int   last_hi     = 0;
  int   last_lo     = 0;
  int   min_run     = 1;

  typedef struct {
    int div;
    int exp_half;
  } vec_t;

  vec_t vecs[9];

  clk_divider dut (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_div     (i_div),
    .i_div_tog (i_div_tog),
    .o_clk     (o_clk)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int lim);
    n_checks++;
    if (act < lim) begin
      n_fail++;
      $display("FAIL %s: run of %0d half-periods, required >= %0d", name, act, lim);
    end
  endtask

  function automatic int eff(input int d);
    return (d <= 1) ? 1 : d;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Samples o_clk 1 ns after every i_clk edge and measures level runs.
  always begin
    @(i_clk);
    #1;
    if (i_rstn) begin
      mon_started = 1'b0;
      last_hi     = 0;
      last_lo     = 0;
    end else if (!mon_started) begin
      mon_started = 1'b1;
      partial     = 1'b1;
      cur_lvl     = o_clk;
      cur_len     = 1;
    end else if (o_clk == cur_lvl) begin
      cur_len++;
    end else begin
      if (!partial) begin
        if (cur_lvl) last_hi = cur_len;
        else         last_lo = cur_len;
        if (runt_en) check_ge("runt_pulse", cur_len, min_run);
      end
      partial = 1'b0;
      cur_lvl = o_clk;
      cur_len = 1;
    end
  end

  task automatic do_toggle(input int d);
    i_div     = d[7:0];
    i_div_tog = ~i_div_tog;
  endtask

  task automatic apply(input int d, input int prev, input string name);
    int w;
    min_run = min2(eff(prev), eff(d));
    @(negedge i_clk);
    do_toggle(d);
    w = 3 + eff(prev) + 4 + 3 * eff(d);
    repeat (w) @(posedge i_clk);
    min_run = eff(d);
    check_eq({name, "_high"}, last_hi, eff(d));
    check_eq({name, "_low"},  last_lo, eff(d));
  endtask

  task automatic wait_o_rise(output bit found);
    bit prev;
    found = 1'b0;
    prev  = o_clk;
    for (int k = 0; k < 600; k++) begin
      @(negedge i_clk);
      #1;
      if (o_clk && !prev) begin
        found = 1'b1;
        break;
      end
      prev = o_clk;
    end
  endtask

  initial begin
    bit found;
    int prev;
    int r;

    vecs[0] = '{div: 4,   exp_half: 4};
    vecs[1] = '{div: 5,   exp_half: 5};
    vecs[2] = '{div: 1,   exp_half: 1};
    vecs[3] = '{div: 6,   exp_half: 6};
    vecs[4] = '{div: 2,   exp_half: 2};
    vecs[5] = '{div: 3,   exp_half: 3};
    vecs[6] = '{div: 0,   exp_half: 1};
    vecs[7] = '{div: 255, exp_half: 255};
    vecs[8] = '{div: 6,   exp_half: 6};

    // Reset: output held low, then bypass with divisor 0
    i_rstn    = 1'b1;
    i_div     = 8'd0;
    i_div_tog = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #27;
      check_eq("reset_low", o_clk, 0);
    end
    #21;
    i_rstn = 1'b0;
    repeat (10) @(posedge i_clk);
    min_run = 1;
    runt_en = 1'b1;
    repeat (6) @(posedge i_clk);
    check_eq("bypass_after_reset_high", last_hi, 1);
    check_eq("bypass_after_reset_low",  last_lo, 1);

    // Directed divisor table
    prev = 0;
    for (int i = 0; i < 9; i++) begin
      min_run = min2(eff(prev), eff(vecs[i].div));
      @(negedge i_clk);
      do_toggle(vecs[i].div);
      repeat (3 + eff(prev) + 4 + 3 * eff(vecs[i].div)) @(posedge i_clk);
      min_run = eff(vecs[i].div);
      check_eq($sformatf("vec%0d_div%0d_high", i, vecs[i].div), last_hi, vecs[i].exp_half);
      check_eq($sformatf("vec%0d_div%0d_low",  i, vecs[i].div), last_lo, vecs[i].exp_half);
      prev = vecs[i].div;
    end

    // Two toggles one cycle apart while dividing by 6: only 7 applies
    wait_o_rise(found);
    check_eq("align_dbl_timeout", found, 1);
    min_run = 6;
    do_toggle(3);
    @(negedge i_clk);
    #1;
    do_toggle(7);
    repeat (3 + 6 + 4 + 21) @(posedge i_clk);
    min_run = 7;
    check_eq("last_wins_high", last_hi, 7);
    check_eq("last_wins_low",  last_lo, 7);

    // Reset in the middle of a divide-by-9 high phase
    apply(9, 7, "div9");
    wait_o_rise(found);
    check_eq("align_rst_timeout", found, 1);
    #12;
    runt_en   = 1'b0;
    i_rstn    = 1'b1;
    #1;
    check_eq("reset_async_low", o_clk, 0);
    i_div_tog = 1'b0;
    i_div     = 8'd0;
    #50;
    check_eq("reset_hold_low", o_clk, 0);
    #50;
    i_rstn = 1'b0;
    repeat (10) @(posedge i_clk);
    min_run = 1;
    runt_en = 1'b1;
    repeat (6) @(posedge i_clk);
    check_eq("post_reset_bypass_high", last_hi, 1);
    check_eq("post_reset_bypass_low",  last_lo, 1);
    apply(4, 0, "post_reset_div4");

    // Random divisors 0..15, one toggle every 2210 ns
    prev = 4;
    for (int it = 0; it < 100; it++) begin
      r = int'($urandom_range(15, 0));
      min_run = min2(eff(prev), eff(r));
      @(negedge i_clk);
      do_toggle(r);
      repeat (70) @(posedge i_clk);
      min_run = eff(r);
      check_eq($sformatf("rand%0d_div%0d_high", it, r), last_hi, eff(r));
      check_eq($sformatf("rand%0d_div%0d_low",  it, r), last_lo, eff(r));
      repeat (150) @(posedge i_clk);
      prev = r;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
